hdmi_line_feeder: RTL and testbench



---
 rtl/hdmi_pkg.sv | 42 ++++
 rtl/line_bank_ram.sv | 27 ++
 rtl/hdmi_line_feeder.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_line_feeder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared timing defaults, write-FSM encoding
// and RGB565 field layout for the HDMI feeder.
package hdmi_pkg;

  localparam int H_PIXEL     = 640;
  localparam int H_TOT_PIXEL = 800;
  localparam int V_PIXEL     = 480;
  localparam int V_TOT_PIXEL = 525;

  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    FILL     = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // MSB replication keeps full-scale at 0xFF
  function automatic rgb888_t rgb565_expand(
    input logic [15:0] p
  );
    logic [4:0] rr;
    logic [5:0] gg;
    logic [4:0] bb;
    rgb888_t    o;
    rr  = p[R_LSB +: 5];
    gg  = p[G_LSB +: 6];
    bb  = p[B_LSB +: 5];
    o.r = {rr, rr[4:2]};
    o.g = {gg, gg[5:4]};
    o.b = {bb, bb[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Two line banks in one simple dual-port RAM,
// addressed {bank, addr}, registered read.
module line_bank_ram #(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk_low,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // write port
  always_ff @(posedge clk_low) begin
    if (we) mem[waddr] <= wdata;
  end

  // synchronous read, no reset for EBR mapping
  always_ff @(posedge clk_low) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdmi_line_feeder.sv
// Ping-pong line buffer between a pixel stream
// and the HDMI raster, with underrun flagging.
module hdmi_line_feeder
  import hdmi_pkg::*;
#(
  parameter int h_pixel     = H_PIXEL,
  parameter int h_tot_pixel = H_TOT_PIXEL,
  parameter int v_pixel     = V_PIXEL,
  parameter int v_tot_pixel = V_TOT_PIXEL
) (
  input  logic        clk_low,
  input  logic        reset,
  input  logic [15:0] in_pixel,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] cntX,
  input  logic [25:0] cntY,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underrun,
  output logic [1:0]  lines_ready
);

  localparam int AW =
    (h_pixel > 1) ? $clog2(h_pixel) : 1;
  localparam int LW = $clog2(v_pixel + 1);

  localparam logic [25:0] X_ACT = 26'(h_pixel);
  localparam logic [25:0] Y_ACT = 26'(v_pixel);
  localparam logic [AW-1:0] A_LAST =
    AW'(h_pixel - 1);
  localparam logic [LW-1:0] L_LAST =
    LW'(v_pixel - 1);

  // resync needs a blanking line to land on
  if (h_tot_pixel <= h_pixel ||
      v_tot_pixel <= v_pixel) begin : g_chk
    $error("blanking must be non-empty");
  end

  wr_state_e     state, state_n;
  logic [AW-1:0] waddr, waddr_n;
  logic          wb, wb_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [1:0]    full, full_n;
  logic          rb;
  logic          line_ok;
  logic          vis_q;
  logic          we;
  logic          line_done;
  logic [15:0]   rdata;
  rgb888_t       rgb;

  logic x_act, y_act;
  logic x_zero;
  logic line_start;
  logic rel;
  logic resync;
  logic ok_now;

  assign x_act      = cntX < X_ACT;
  assign y_act      = cntY < Y_ACT;
  assign x_zero     = cntX == '0;
  assign line_start = y_act && x_zero;
  assign rel        = y_act && line_ok &&
                      (cntX == X_ACT);
  assign resync     = x_zero && (cntY == Y_ACT);
  assign ok_now     = x_zero ? full[rb] : line_ok;

  // write FSM: next state, address and strobes
  always_comb begin
    state_n   = state;
    waddr_n   = waddr;
    wb_n      = wb;
    lcnt_n    = lcnt;
    we        = 1'b0;
    line_done = 1'b0;
    in_ready  = 1'b1;
    unique case (state)
      WAIT_SOF: begin
        in_ready = 1'b1;
        if (in_valid && in_sof) begin
          we      = 1'b1;
          waddr_n = AW'(1);
          state_n = FILL;
        end
      end
      FILL: begin
        in_ready = !full[wb];
        if (in_valid && !full[wb]) begin
          we = 1'b1;
          if (waddr == A_LAST) begin
            line_done = 1'b1;
            wb_n      = !wb;
            waddr_n   = '0;
            lcnt_n    = lcnt + 1'b1;
            if (lcnt == L_LAST) begin
              state_n = WAIT_SOF;
              lcnt_n  = '0;
            end
          end else begin
            waddr_n = waddr + 1'b1;
          end
        end
      end
      default: state_n = WAIT_SOF;
    endcase
    if (resync) begin
      state_n   = WAIT_SOF;
      waddr_n   = '0;
      wb_n      = 1'b0;
      lcnt_n    = '0;
      we        = 1'b0;
      line_done = 1'b0;
    end
  end

  // full flags: release and completion hit
  // different banks, resync clears both
  always_comb begin
    full_n = full;
    if (rel)       full_n[rb] = 1'b0;
    if (line_done) full_n[wb] = 1'b1;
    if (resync)    full_n     = '0;
  end

  // write-side state register
  always_ff @(posedge clk_low) begin
    if (reset) begin
      state <= WAIT_SOF;
      waddr <= '0;
      wb    <= 1'b0;
      lcnt  <= '0;
    end else begin
      state <= state_n;
      waddr <= waddr_n;
      wb    <= wb_n;
      lcnt  <= lcnt_n;
    end
  end

  // bank ownership and read bank pointer
  always_ff @(posedge clk_low) begin
    if (reset) begin
      full <= '0;
      rb   <= 1'b0;
    end else begin
      full <= full_n;
      if (resync)   rb <= 1'b0;
      else if (rel) rb <= !rb;
    end
  end

  // per-line grant and sticky underrun
  always_ff @(posedge clk_low) begin
    if (reset) begin
      line_ok  <= 1'b0;
      underrun <= 1'b0;
    end else if (line_start) begin
      line_ok <= full[rb];
      if (!full[rb]) underrun <= 1'b1;
    end
  end

  // visibility travels alongside the RAM read
  always_ff @(posedge clk_low) begin
    if (reset) vis_q <= 1'b0;
    else       vis_q <= x_act && y_act && ok_now;
  end

  line_bank_ram #(
    .DW (16),
    .AW (AW + 1)
  ) u_ram (
    .clk_low (clk_low),
    .we      (we),
    .waddr   ({wb, waddr}),
    .wdata   (in_pixel),
    .raddr   ({rb, cntX[AW-1:0]}),
    .rdata   (rdata)
  );

  // black outside the draw area and on underrun
  always_comb begin
    rgb = '0;
    if (vis_q) rgb = rgb565_expand(rdata);
  end

  assign red   = rgb.r;
  assign green = rgb.g;
  assign blue  = rgb.b;

  assign lines_ready = {1'b0, full[0]} +
                       {1'b0, full[1]};

endmodule

// File: tb/tb_hdmi_line_feeder.sv
// Directed bench for hdmi_line_feeder using
// small raster parameters (8x4 in 12x6).
module tb_hdmi_line_feeder;

  logic        clk_low = 1'b0;
  logic        reset;
  logic [15:0] in_pixel;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] cntX;
  logic [25:0] cntY;
  logic [7:0]  red, green, blue;
  logic        underrun;
  logic [1:0]  lines_ready;

  int checks = 0;
  int errors = 0;

  typedef logic [0:7][15:0] pline_t;
  typedef logic [0:7][23:0] eline_t;

  pline_t pA = '{16'hF800, 16'h07E0, 16'h001F,
                 16'h8410, 16'h1234, 16'hFFFF,
                 16'h0000, 16'hF800};
  eline_t eA = '{24'hFF0000, 24'h00FF00,
                 24'h0000FF, 24'h848284,
                 24'h1045A5, 24'hFFFFFF,
                 24'h000000, 24'hFF0000};
  pline_t pB = '{16'h07E0, 16'h001F, 16'hF800,
                 16'h0841, 16'h001F, 16'hF800,
                 16'h07E0, 16'h001F};
  eline_t eB = '{24'h00FF00, 24'h0000FF,
                 24'hFF0000, 24'h080808,
                 24'h0000FF, 24'hFF0000,
                 24'h00FF00, 24'h0000FF};
  pline_t pC = '{16'h001F, 16'h1234, 16'h8410,
                 16'hFFFF, 16'h0841, 16'h0000,
                 16'h07E0, 16'hF800};
  eline_t eC = '{24'h0000FF, 24'h1045A5,
                 24'h848284, 24'hFFFFFF,
                 24'h080808, 24'h000000,
                 24'h00FF00, 24'hFF0000};
  pline_t pD = '{16'h8410, 16'h1234, 16'h0841,
                 16'hF800, 16'h07E0, 16'h001F,
                 16'hFFFF, 16'h0000};
  eline_t eD = '{24'h848284, 24'h1045A5,
                 24'h080808, 24'hFF0000,
                 24'h00FF00, 24'h0000FF,
                 24'hFFFFFF, 24'h000000};
  pline_t pE = '{16'h1234, 16'h0841, 16'h8410,
                 16'h001F, 16'h07E0, 16'hF800,
                 16'h0000, 16'hFFFF};
  eline_t eE = '{24'h1045A5, 24'h080808,
                 24'h848284, 24'h0000FF,
                 24'h00FF00, 24'hFF0000,
                 24'h000000, 24'hFFFFFF};
  pline_t pF = '{16'hFFFF, 16'hFFFF, 16'hFFFF,
                 16'hFFFF, 16'hFFFF, 16'hFFFF,
                 16'hFFFF, 16'hFFFF};
  eline_t eZ = '{24'h0, 24'h0, 24'h0, 24'h0,
                 24'h0, 24'h0, 24'h0, 24'h0};

  hdmi_line_feeder #(
    .h_pixel     (8),
    .h_tot_pixel (12),
    .v_pixel     (4),
    .v_tot_pixel (6)
  ) dut (
    .clk_low     (clk_low),
    .reset       (reset),
    .in_pixel    (in_pixel),
    .in_sof      (in_sof),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cntX        (cntX),
    .cntY        (cntY),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .underrun    (underrun),
    .lines_ready (lines_ready)
  );

  always #5 clk_low = !clk_low;

  task automatic tick();
    @(posedge clk_low);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'h0, red, green, blue};
  endfunction

  task automatic feed_line(input pline_t p,
                           input logic sof0);
    for (int i = 0; i < 8; i++) begin
      in_pixel = p[i];
      in_sof   = sof0 && (i == 0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_line(input int y,
                          input eline_t e,
                          input int lrb,
                          input int lra,
                          input logic irb,
                          input logic ira);
    for (int x = 0; x < 12; x++) begin
      cntY = 26'(y);
      cntX = 26'(x);
      if (x == 8) begin
        chk($sformatf("lr_pre y%0d", y),
            32'(lines_ready), 32'(lrb));
        chk($sformatf("rdy_pre y%0d", y),
            32'(in_ready), 32'(irb));
      end
      tick();
      chk($sformatf("rgb y%0d x%0d", y, x),
          rgb_now(),
          (x < 8) ? {8'h0, e[x]} : 32'h0);
      if (x == 8) begin
        chk($sformatf("lr_post y%0d", y),
            32'(lines_ready), 32'(lra));
        chk($sformatf("rdy_post y%0d", y),
            32'(in_ready), 32'(ira));
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_pixel = '0;
    in_sof   = 1'b0;
    in_valid = 1'b0;
    cntX     = 26'd0;
    cntY     = 26'd5;
    tick();
    tick();
    reset = 1'b0;

    chk("rst rgb", rgb_now(), 32'h0);
    chk("rst ready", 32'(in_ready), 32'h1);
    chk("rst underrun", 32'(underrun), 32'h0);
    chk("rst lines", 32'(lines_ready), 32'h0);

    // idle raster: underrun one cycle after 0,0
    cntY = 26'd0;
    cntX = 26'd0;
    tick();
    chk("idle underrun", 32'(underrun), 32'h1);
    chk("idle rgb0", rgb_now(), 32'h0);
    for (int x = 1; x < 12; x++) begin
      cntX = 26'(x);
      tick();
      chk($sformatf("idle rgb x%0d", x),
          rgb_now(), 32'h0);
    end
    chk("idle ready", 32'(in_ready), 32'h1);

    cntX  = 26'd0;
    cntY  = 26'd5;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2 underrun", 32'(underrun), 32'h0);

    // two lines with no raster progress
    feed_line(pA, 1'b1);
    feed_line(pB, 1'b0);
    chk("both full lr", 32'(lines_ready), 32'h2);
    chk("both full rdy", 32'(in_ready), 32'h0);

    run_line(0, eA, 2, 1, 1'b0, 1'b1);
    run_line(1, eB, 1, 0, 1'b1, 1'b1);
    chk("no underrun", 32'(underrun), 32'h0);

    // starved line, then a late fill
    run_line(2, eZ, 0, 0, 1'b1, 1'b1);
    chk("starve underrun", 32'(underrun), 32'h1);
    feed_line(pC, 1'b0);
    chk("late fill lr", 32'(lines_ready), 32'h1);
    run_line(3, eC, 1, 0, 1'b1, 1'b1);

    // partial fill, then resync with a write
    for (int i = 0; i < 3; i++) begin
      in_pixel = pF[i];
      in_valid = 1'b1;
      tick();
    end
    cntY = 26'd4;
    cntX = 26'd0;
    tick();
    in_valid = 1'b0;
    chk("resync lr", 32'(lines_ready), 32'h0);
    chk("resync rdy", 32'(in_ready), 32'h1);

    cntY = 26'd5;
    cntX = 26'd1;
    feed_line(pF, 1'b0);
    chk("no sof drop", 32'(lines_ready), 32'h0);
    feed_line(pD, 1'b1);
    chk("sof fill lr", 32'(lines_ready), 32'h1);
    feed_line(pE, 1'b1);
    chk("mid sof lr", 32'(lines_ready), 32'h2);
    chk("mid sof rdy", 32'(in_ready), 32'h0);

    run_line(0, eD, 2, 1, 1'b0, 1'b1);

    // reset in the middle of a visible line
    for (int x = 0; x < 3; x++) begin
      cntY = 26'd1;
      cntX = 26'(x);
      tick();
      chk($sformatf("pre-rst x%0d", x),
          rgb_now(), {8'h0, eE[x]});
    end
    cntX  = 26'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst rgb", rgb_now(), 32'h0);
    chk("mid rst rdy", 32'(in_ready), 32'h1);
    chk("mid rst und", 32'(underrun), 32'h0);
    chk("mid rst lr", 32'(lines_ready), 32'h0);
    cntX = 26'd4;
    tick();
    chk("post rst rgb", rgb_now(), 32'h0);
    cntY = 26'd2;
    cntX = 26'd0;
    tick();
    chk("post rst und", 32'(underrun), 32'h1);
    chk("post rst rgb0", rgb_now(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
